// File: rtl/robo_pkg.sv
// robo_pkg: shared definitions for the wall-following robot controller.
//   - Default values for the FILT_LEN, ROT_CYCLES and MAX_ROTS parameters.
//   - The 3-bit FSM state encoding (values 5-7 are unused).
//   - drive_t and decode_drive(): the Moore output decode used by the top level.
package robo_pkg;

  localparam int unsigned FILT_LEN_DEF   = 3;
  localparam int unsigned ROT_CYCLES_DEF = 4;
  localparam int unsigned MAX_ROTS_DEF   = 4;

  localparam int unsigned STATE_W = 3;

  localparam logic [2:0] ST_SEARCH  = 3'd0;
  localparam logic [2:0] ST_FOLLOW  = 3'd1;
  localparam logic [2:0] ST_ROTATE  = 3'd2;
  localparam logic [2:0] ST_REROUTE = 3'd3;
  localparam logic [2:0] ST_STUCK   = 3'd4;

  typedef struct packed {
    logic front;
    logic rotate;
    logic stuck;
  } drive_t;

  // Unused encodings drive nothing; they last a single cycle before SEARCH.
  function automatic drive_t decode_drive(input logic [2:0] st);
    drive_t d;
    d = '0;
    case (st)
      ST_SEARCH,
      ST_FOLLOW:  d.front  = 1'b1;
      ST_ROTATE,
      ST_REROUTE: d.rotate = 1'b1;
      ST_STUCK:   d.stuck  = 1'b1;
      default:    d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/sensor_filter.sv
// sensor_filter: debounce filter for one raw sensor bit.
// The filtered output changes only after FILT_LEN consecutive raw samples that
// differ from it; any sample equal to the current filtered value restarts the run.
// Ports:
//   clk   in  clock, rising edge
//   reset in  synchronous active-high reset (filt -> 0, run count -> 0)
//   raw   in  raw sensor sample
//   filt  out filtered sensor value (registered)
module sensor_filter
  import robo_pkg::*;
#(
  parameter int unsigned FILT_LEN = FILT_LEN_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic filt
);

  localparam int unsigned CNT_W = $clog2(FILT_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_filt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_filt_next;

  always_comb begin
    w_cnt_next  = '0;
    w_filt_next = r_filt;
    if (raw != r_filt) begin
      // This sample completes the run: adopt it and start counting afresh.
      if (r_cnt == CNT_LAST) begin
        w_filt_next = raw;
      end else begin
        w_cnt_next = r_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_filt <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_next;
      r_filt <= w_filt_next;
    end
  end

  assign filt = r_filt;

endmodule

// File: rtl/wall_follower.sv
// wall_follower: left-wall-following robot controller.
// Both sensors are debounced by sensor_filter; the FSM sees only filtered values.
// ROTATE turns in steps of ROT_CYCLES cycles, checking the sensors at each step
// end; after MAX_ROTS fruitless steps it halts in STUCK until reset.
// REROUTE turns for exactly ROT_CYCLES cycles and then resumes SEARCH.
// Ports:
//   clk    in  clock, rising edge
//   reset  in  synchronous active-high reset, overrides every transition
//   head   in  raw obstacle-ahead sensor
//   left   in  raw wall-on-left sensor
//   front  out drive forward        (SEARCH, FOLLOW)
//   rotate out rotate in place      (ROTATE, REROUTE)
//   stuck  out halted, no wall found (STUCK)
//   state  out current state encoding for debug
module wall_follower
  import robo_pkg::*;
#(
  parameter int unsigned FILT_LEN   = FILT_LEN_DEF,
  parameter int unsigned ROT_CYCLES = ROT_CYCLES_DEF,
  parameter int unsigned MAX_ROTS   = MAX_ROTS_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       head,
  input  logic       left,
  output logic       front,
  output logic       rotate,
  output logic       stuck,
  output logic [2:0] state
);

  localparam int unsigned STEP_W = $clog2(ROT_CYCLES + 1);
  localparam int unsigned ROT_W  = $clog2(MAX_ROTS + 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(ROT_CYCLES - 1);
  // rot_cnt + 1 == MAX_ROTS, expressed without widening the counter.
  localparam logic [ROT_W-1:0]  ROT_LAST  = ROT_W'(MAX_ROTS - 1);

  logic       w_h;
  logic       w_l;
  logic [1:0] w_hl;

  logic [2:0]        r_state;
  logic [STEP_W-1:0] r_step;
  logic [ROT_W-1:0]  r_rot;
  logic [2:0]        w_state_next;
  logic [STEP_W-1:0] w_step_next;
  logic [ROT_W-1:0]  w_rot_next;
  drive_t            w_drive;

  sensor_filter #(
    .FILT_LEN (FILT_LEN)
  ) u_head_filter (
    .clk   (clk),
    .reset (reset),
    .raw   (head),
    .filt  (w_h)
  );

  sensor_filter #(
    .FILT_LEN (FILT_LEN)
  ) u_left_filter (
    .clk   (clk),
    .reset (reset),
    .raw   (left),
    .filt  (w_l)
  );

  assign w_hl = {w_h, w_l};

  // Counters default to zero, so every entry into ROTATE or REROUTE starts clean.
  always_comb begin
    w_state_next = r_state;
    w_step_next  = '0;
    w_rot_next   = '0;
    case (r_state)
      ST_SEARCH: begin
        if (w_hl == 2'b01) begin
          w_state_next = ST_FOLLOW;
        end else if (w_h) begin
          w_state_next = ST_ROTATE;
        end
      end
      ST_FOLLOW: begin
        case (w_hl)
          2'b01:   w_state_next = ST_FOLLOW;
          2'b11:   w_state_next = ST_ROTATE;
          default: w_state_next = ST_REROUTE;
        endcase
      end
      ST_ROTATE: begin
        if (r_step == STEP_LAST) begin
          if (w_hl == 2'b01) begin
            w_state_next = ST_FOLLOW;
          end else if (r_rot == ROT_LAST) begin
            w_state_next = ST_STUCK;
          end else begin
            w_rot_next = r_rot + ROT_W'(1);
          end
        end else begin
          // Sensors are ignored mid-step.
          w_step_next = r_step + STEP_W'(1);
          w_rot_next  = r_rot;
        end
      end
      ST_REROUTE: begin
        if (r_step == STEP_LAST) begin
          w_state_next = ST_SEARCH;
        end else begin
          w_step_next = r_step + STEP_W'(1);
        end
      end
      ST_STUCK: begin
        w_state_next = ST_STUCK;
      end
      default: begin
        w_state_next = ST_SEARCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_SEARCH;
      r_step  <= '0;
      r_rot   <= '0;
    end else begin
      r_state <= w_state_next;
      r_step  <= w_step_next;
      r_rot   <= w_rot_next;
    end
  end

  assign w_drive = decode_drive(r_state);
  assign front   = w_drive.front;
  assign rotate  = w_drive.rotate;
  assign stuck   = w_drive.stuck;
  assign state   = r_state;

endmodule

// File: doc/wall_follower.md
WALL_FOLLOWER -- requirements
Module: wall_follower

Interface
REQ-001 Parameter FILT_LEN, default 3: consecutive identical raw samples needed to change a filtered sensor value; legal range >=1.
REQ-002 Parameter ROT_CYCLES, default 4: clock cycles per rotation step; legal range >=1.
REQ-003 Parameter MAX_ROTS, default 4: rotation steps in ROTATE without finding a wall before STUCK; legal range >=1.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 head  input  1  raw obstacle-ahead sensor.
REQ-007 left  input  1  raw wall-on-left sensor.
REQ-008 front  output  1  drive forward.
REQ-009 rotate  output  1  rotate in place.
REQ-010 stuck  output  1  controller halted, no wall found.
REQ-011 state  output  3  current state encoding, for debug.

Function
REQ-012 Each sensor SHALL pass through a filter: filtered value changes on the edge that takes the FILT_LEN-th consecutive raw sample differing from the current filtered value; any sample equal to the filtered value clears the run count.
REQ-013 FSM transitions SHALL use only the filtered values {h,l}; the raw-to-state latency for a stable input SHALL be FILT_LEN+1 edges.
REQ-014 States and encoding: SEARCH=0, FOLLOW=1, ROTATE=2, REROUTE=3, STUCK=4; encodings 5-7 SHALL go to SEARCH on the next edge.
REQ-015 Outputs SHALL be Moore, decoded from state only: SEARCH and FOLLOW give front=1, rotate=0; ROTATE and REROUTE give front=0, rotate=1; STUCK gives front=0, rotate=0, stuck=1; stuck=0 in all other states.
REQ-016 SEARCH: {h,l}=00 -> SEARCH; 01 -> FOLLOW; 10 or 11 -> ROTATE.
REQ-017 FOLLOW: 01 -> FOLLOW; 00 or 10 -> REROUTE; 11 -> ROTATE.
REQ-018 ROTATE: entry clears step_cnt and rot_cnt; step_cnt counts 0..ROT_CYCLES-1; {h,l} is ignored until step end (step_cnt==ROT_CYCLES-1).
REQ-019 At ROTATE step end: 01 -> FOLLOW; otherwise rot_cnt+1, and if rot_cnt+1==MAX_ROTS -> STUCK, else remain in ROTATE with step_cnt=0.
REQ-020 REROUTE: assert rotate for exactly ROT_CYCLES cycles regardless of inputs, then -> SEARCH.
REQ-021 STUCK SHALL be absorbing; it exits only via reset.
REQ-022 Counter widths SHALL be $clog2(P+1) for each parameter P; counters never wrap inside legal operation.
REQ-023 With ROT_CYCLES=1, every ROTATE cycle SHALL be a step end.

Reset
REQ-024 When reset=1 at an edge: state=SEARCH, all counters=0, filtered head=0, filtered left=0; outputs on the next cycle are front=1, rotate=0, stuck=0, state=0.
REQ-025 Reset SHALL take priority over every transition, including mid-step in ROTATE or REROUTE and in STUCK.

Structure
REQ-026 The state encoding constants and the parameter defaults SHALL live in shared package robo_pkg.
REQ-027 The sensor filter SHALL be sub-module sensor_filter (parameter FILT_LEN; ports clk, reset, raw, filt), instantiated once per sensor.
REQ-028 The top level SHALL contain only the FSM, the step/rotation counters and the output decode.

Verification (default parameters)
REQ-029 Reset held 2 cycles from arbitrary state -> state=0, front=1, rotate=0, stuck=0.
REQ-030 left=1 for 2 cycles, then 0 -> state stays SEARCH; left=1 held -> state=FOLLOW after the 4th edge.
REQ-031 Filtered head=1 in SEARCH -> ROTATE; rotate=1 for 4 cycles; {h,l}=01 at step end -> FOLLOW with front=1 on the next cycle.
REQ-032 head=1, left=1 held -> exactly 16 cycles in ROTATE, then STUCK with front=0, rotate=0, stuck=1; stays STUCK for 100 cycles until reset.
REQ-033 In FOLLOW, left drops (filtered) -> REROUTE, rotate=1 for 4 cycles, then SEARCH.
REQ-034 reset pulsed at step_cnt=2 of the 2nd ROTATE step -> SEARCH next edge; a later ROTATE entry takes a full 16 cycles to reach STUCK.
